// File: rtl/inst_queue_if.sv
// Push/pop handshake bundle between decode, issue and the instruction queue.
// The queue takes the slave modport; decode/issue (or a bench) drive the master side.
interface inst_queue_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        push_num;
    logic [DATA_W-1:0] push_data0;
    logic [DATA_W-1:0] push_data1;
    logic [1:0]        pop_req;
    logic [DATA_W-1:0] pop_data0;
    logic [DATA_W-1:0] pop_data1;
    logic              pop_valid0;
    logic              pop_valid1;
    logic [1:0]        pop_num;

    modport master (
        output push_num, push_data0, push_data1, pop_req,
        input  pop_data0, pop_data1, pop_valid0, pop_valid1, pop_num
    );

    modport slave (
        input  push_num, push_data0, push_data1, pop_req,
        output pop_data0, pop_data1, pop_valid0, pop_valid1, pop_num
    );
endinterface

// File: rtl/inst_queue.sv
// Dual-ported in-order instruction queue (2 pushes / 2 pops per cycle) with flush and stall gating.
// Optional: define IQ_FULL_CNT_EN to count cycles spent with stall_from_decode asserted.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    inst_queue_if.slave                iq,
    input  logic                       stall_to_id_is,
    input  logic                       stall_to_is,
    input  logic                       flash_to_iq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       stall_from_decode,
    output logic [31:0]                full_cycles
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     cnt_r;

    logic [1:0]        push_eff;
    logic [1:0]        pop_eff;
    logic [1:0]        pop_n;
    logic [1:0]        push_acc;
    logic [CW-1:0]     free_slots;
    logic [PW-1:0]     head_nx1;
    logic [PW-1:0]     tail_nx1;

    assign head_nx1   = head_r + PW'(1);
    assign tail_nx1   = tail_r + PW'(1);
    assign free_slots = DEPTH_C - cnt_r;

    // Free space is taken before this cycle's pops, so pops never make room for same-cycle pushes.
    always_comb begin
        push_eff = (iq.push_num == 2'd3) ? 2'd2 : iq.push_num;
        pop_eff  = (iq.pop_req  == 2'd3) ? 2'd2 : iq.pop_req;
        pop_n    = 2'd0;
        push_acc = 2'd0;
        if (!flash_to_iq) begin
            if (!stall_to_is)
                pop_n = ({{(CW-2){1'b0}}, pop_eff} > cnt_r) ? cnt_r[1:0] : pop_eff;
            if (!stall_to_id_is)
                push_acc = ({{(CW-2){1'b0}}, push_eff} > free_slots) ? free_slots[1:0] : push_eff;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= '0;
        end else if (flash_to_iq) begin
            head_r <= '0;
            tail_r <= '0;
            cnt_r  <= '0;
        end else begin
            head_r <= head_r + PW'(pop_n);
            tail_r <= tail_r + PW'(push_acc);
            cnt_r  <= cnt_r - CW'(pop_n) + CW'(push_acc);
        end
    end

    // Storage is deliberately left unreset; valids qualify every read.
    always_ff @(posedge clk) begin
        if (push_acc != 2'd0)
            mem[tail_r] <= iq.push_data0;
        if (push_acc == 2'd2)
            mem[tail_nx1] <= iq.push_data1;
    end

    assign iq.pop_data0  = mem[head_r];
    assign iq.pop_data1  = mem[head_nx1];
    assign iq.pop_valid0 = !flash_to_iq && (cnt_r != '0);
    assign iq.pop_valid1 = !flash_to_iq && (cnt_r >= CW'(2));
    assign iq.pop_num    = pop_n;
    assign count         = cnt_r;

    // Registered-count only: no path from any input, which keeps pipeline control loop-free.
    assign stall_from_decode = (free_slots < CW'(2));

`ifdef IQ_FULL_CNT_EN
    logic [31:0] full_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            full_cnt_r <= '0;
        else if (stall_from_decode && (full_cnt_r != 32'hFFFF_FFFF))
            full_cnt_r <= full_cnt_r + 32'd1;
    end

    assign full_cycles = full_cnt_r;
`else
    assign full_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_inst_queue;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_to_id_is;
    logic        stall_to_is;
    logic        flash_to_iq;
    logic [3:0]  count;
    logic        stall_from_decode;
    logic [31:0] full_cycles;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] mq[$];
    int unsigned fc_m = 0;

    inst_queue_if #(.DATA_W(DATA_W)) iq ();

    inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .iq                (iq),
        .stall_to_id_is    (stall_to_id_is),
        .stall_to_is       (stall_to_is),
        .flash_to_iq       (flash_to_iq),
        .count             (count),
        .stall_from_decode (stall_from_decode),
        .full_cycles       (full_cycles)
    );

    always #5 clk = ~clk;

    function automatic int eff(input logic [1:0] v);
        return (v == 2'd3) ? 2 : int'(v);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int exp_popn();
        if (flash_to_iq || stall_to_is) return 0;
        return imin(eff(iq.pop_req), mq.size());
    endfunction

    function automatic bit exp_stall();
        return (DEPTH - mq.size()) < 2;
    endfunction

    task automatic drive(input int pn, input int pr, input bit sid, input bit sis, input bit fl);
        iq.push_num    = 2'(pn);
        iq.pop_req     = 2'(pr);
        iq.push_data0  = {$urandom, $urandom};
        iq.push_data1  = {$urandom, $urandom};
        stall_to_id_is = sid;
        stall_to_is    = sis;
        flash_to_iq    = fl;
        #1;
    endtask

    task automatic tick();
        int popn, acc, free;
        bit st, fl;
        logic [DATA_W-1:0] d0, d1;
        st   = exp_stall();
        fl   = flash_to_iq;
        popn = exp_popn();
        free = DEPTH - mq.size();
        acc  = (fl || stall_to_id_is) ? 0 : imin(eff(iq.push_num), free);
        d0   = iq.push_data0;
        d1   = iq.push_data1;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            repeat (popn) void'(mq.pop_front());
            if (acc >= 1) mq.push_back(d0);
            if (acc == 2) mq.push_back(d1);
        end
`ifdef IQ_FULL_CNT_EN
        if (st && fc_m != 32'hFFFF_FFFF) fc_m++;
`else
        if (st) fc_m = 0;
`endif
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (iq.pop_valid0 !== 1'b0 || iq.pop_valid1 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b%b expected 00", iq.pop_valid0, iq.pop_valid1); end
        tests++; if (iq.pop_num !== 2'd0) begin fails++; $display("FAIL reset_pop_num: got %0d expected 0", iq.pop_num); end
        tests++; if (stall_from_decode !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_from_decode); end
        tests++; if (full_cycles !== 32'd0) begin fails++; $display("FAIL reset_full_cycles: got %0d expected 0", full_cycles); end
        rst = 1'b0;
        mq.delete();
        fc_m = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(2, 0, 0, 0, 0);
            tests++; if (count !== 4'(2 * i)) begin fails++; $display("FAIL fill_count: got %0d expected %0d", count, 2 * i); end
            tests++; if (stall_from_decode !== 1'b0) begin fails++; $display("FAIL fill_stall_low: got %b expected 0", stall_from_decode); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_full_count: got %0d expected 8", count); end
        tests++; if (stall_from_decode !== 1'b1) begin fails++; $display("FAIL fill_stall_high: got %b expected 1", stall_from_decode); end
        tests++; if (iq.pop_valid1 !== 1'b1) begin fails++; $display("FAIL fill_valid1: got %b expected 1", iq.pop_valid1); end
    endtask

    task automatic test_full_push_pop();
        drive(2, 2, 0, 0, 0);
        tests++; if (iq.pop_num !== 2'd2) begin fails++; $display("FAIL fullpp_pop_num: got %0d expected 2", iq.pop_num); end
        tests++; if (iq.pop_data0 !== mq[0]) begin fails++; $display("FAIL fullpp_data0: got %h expected %h", iq.pop_data0, mq[0]); end
        tests++; if (iq.pop_data1 !== mq[1]) begin fails++; $display("FAIL fullpp_data1: got %h expected %h", iq.pop_data1, mq[1]); end
        tick();
        drive(0, 0, 0, 0, 0);
        tests++; if (count !== 4'd6) begin fails++; $display("FAIL fullpp_count: got %0d expected 6", count); end
        tests++; if (stall_from_decode !== 1'b0) begin fails++; $display("FAIL fullpp_stall: got %b expected 0", stall_from_decode); end
    endtask

    task automatic test_wrap();
        while (mq.size() > 1) begin
            drive(0, imin(2, mq.size() - 1), 0, 0, 0);
            tests++; if (iq.pop_data0 !== mq[0]) begin fails++; $display("FAIL drain_data0: got %h expected %h", iq.pop_data0, mq[0]); end
            tick();
        end
        drive(2, 2, 0, 0, 0);
        tests++; if (iq.pop_num !== 2'd1) begin fails++; $display("FAIL wrap_pop_num: got %0d expected 1", iq.pop_num); end
        tests++; if (iq.pop_valid1 !== 1'b0) begin fails++; $display("FAIL wrap_valid1: got %b expected 0", iq.pop_valid1); end
        tick();
        drive(0, 0, 0, 0, 0);
        tests++; if (count !== 4'd2) begin fails++; $display("FAIL wrap_count: got %0d expected 2", count); end
        tests++; if (iq.pop_data0 !== mq[0]) begin fails++; $display("FAIL wrap_data0: got %h expected %h", iq.pop_data0, mq[0]); end
        tests++; if (iq.pop_data1 !== mq[1]) begin fails++; $display("FAIL wrap_data1: got %h expected %h", iq.pop_data1, mq[1]); end
    endtask

    task automatic test_flush();
        while (mq.size() < 5) begin
            drive((mq.size() <= 3) ? 2 : 1, 0, 0, 0, 0);
            tick();
        end
        drive(2, 2, 0, 0, 1);
        tests++; if (iq.pop_valid0 !== 1'b0 || iq.pop_valid1 !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b%b expected 00", iq.pop_valid0, iq.pop_valid1); end
        tests++; if (iq.pop_num !== 2'd0) begin fails++; $display("FAIL flush_pop_num: got %0d expected 0", iq.pop_num); end
        tests++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        tick();
        drive(0, 0, 0, 0, 0);
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", count); end
        tests++; if (stall_from_decode !== 1'b0 || iq.pop_valid0 !== 1'b0) begin fails++; $display("FAIL flush_after: got stall %b valid0 %b expected 0 0", stall_from_decode, iq.pop_valid0); end
    endtask

    task automatic test_stalls();
        logic [DATA_W-1:0] head_before;
        repeat (2) begin drive(2, 0, 0, 0, 0); tick(); end
        drive(0, 2, 0, 1, 0);
        head_before = mq[0];
        tests++; if (iq.pop_num !== 2'd0) begin fails++; $display("FAIL stall_is_pop_num: got %0d expected 0", iq.pop_num); end
        tick();
        drive(2, 0, 1, 0, 0);
        tests++; if (count !== 4'd4) begin fails++; $display("FAIL stall_is_count: got %0d expected 4", count); end
        tests++; if (iq.pop_data0 !== head_before) begin fails++; $display("FAIL stall_is_head: got %h expected %h", iq.pop_data0, head_before); end
        tick();
        drive(0, 0, 0, 0, 0);
        tests++; if (count !== 4'd4) begin fails++; $display("FAIL stall_id_count: got %0d expected 4", count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0));
            tests++;
            if (count !== 4'(mq.size()) || stall_from_decode !== exp_stall() || iq.pop_num !== 2'(exp_popn())) begin
                fails++;
                $display("FAIL rand_ctrl cyc %0d: got count %0d stall %b pop_num %0d expected %0d %b %0d",
                         i, count, stall_from_decode, iq.pop_num, mq.size(), exp_stall(), exp_popn());
            end
            tests++;
            if (iq.pop_valid0 !== (!flash_to_iq && mq.size() >= 1) || iq.pop_valid1 !== (!flash_to_iq && mq.size() >= 2)) begin
                fails++;
                $display("FAIL rand_valid cyc %0d: got %b%b size %0d flush %b", i, iq.pop_valid0, iq.pop_valid1, mq.size(), flash_to_iq);
            end
            if (mq.size() >= 1) begin
                tests++;
                if (iq.pop_data0 !== mq[0]) begin fails++; $display("FAIL rand_data0 cyc %0d: got %h expected %h", i, iq.pop_data0, mq[0]); end
            end
            if (mq.size() >= 2) begin
                tests++;
                if (iq.pop_data1 !== mq[1]) begin fails++; $display("FAIL rand_data1 cyc %0d: got %h expected %h", i, iq.pop_data1, mq[1]); end
            end
            tests++;
            if (full_cycles !== fc_m) begin fails++; $display("FAIL rand_full_cycles cyc %0d: got %0d expected %0d", i, full_cycles, fc_m); end
            tick();
        end
    endtask

    task automatic test_full_cnt();
        int exp_fc;
        // Fresh start so the counter begins from zero.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mq.delete();
        fc_m = 0;
        @(posedge clk); #1;
        repeat (4) begin drive(2, 0, 0, 0, 0); tick(); end
        repeat (9) begin drive(0, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 1);
        tick();
`ifdef IQ_FULL_CNT_EN
        exp_fc = 10;
`else
        exp_fc = 0;
`endif
        drive(0, 0, 0, 0, 0);
        tests++; if (full_cycles !== 32'(exp_fc)) begin fails++; $display("FAIL fullcnt_after_hold: got %0d expected %0d", full_cycles, exp_fc); end
        tick();
        tick();
        tests++; if (full_cycles !== 32'(exp_fc)) begin fails++; $display("FAIL fullcnt_after_flush: got %0d expected %0d", full_cycles, exp_fc); end
        // Refill partially, then reset asynchronously away from any edge.
        repeat (3) begin drive(2, 0, 0, 0, 0); tick(); end
        drive(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL async_rst_count: got %0d expected 0", count); end
        tests++; if (full_cycles !== 32'd0 || iq.pop_valid0 !== 1'b0) begin fails++; $display("FAIL async_rst_state: got full_cycles %0d valid0 %b expected 0 0", full_cycles, iq.pop_valid0); end
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        fc_m = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_stalls();
        test_random();
        test_full_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
